// File: rtl/enigma_decipher_if.sv
// Handshake bundle between a ciphertext producer and the deciphering block.
// The master drives ciphertext and consumes plaintext; the slave deciphers.
interface enigma_decipher_if;
  logic       cipher_valid;
  logic       cipher_ready;
  logic [7:0] cipher_in;
  logic       plain_valid;
  logic       plain_ready;
  logic [7:0] plain_out;

  modport master (
    output cipher_valid, cipher_in, plain_ready,
    input  cipher_ready, plain_valid, plain_out
  );

  modport slave (
    input  cipher_valid, cipher_in, plain_ready,
    output cipher_ready, plain_valid, plain_out
  );
endinterface

// File: rtl/enigma_decipher.sv
// Three-rotor Caesar-style decipher stage. Letters are shifted back by the
// rotor sum (mod 26) with case preserved; the rotors advance odometer-style
// on every deciphered letter. One-deep output register with full-rate
// streaming when the consumer is ready.
module enigma_decipher #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               load_init_state,
  input  logic [4:0]         rotor_init_state,
  input  logic [4:0]         rotor2_init_state,
  input  logic [4:0]         rotor3_init_state,
  enigma_decipher_if.slave   cipher_bus,
  output logic [COUNT_W-1:0] letter_count
);

  // Load values above 25 fold back into the 0-25 range.
  function automatic logic [4:0] reduce_init(input logic [4:0] v);
    logic [4:0] r;
    if (v >= 5'd26) r = v - 5'd26;
    else            r = v;
    return r;
  endfunction

  // Sum of three 0-25 rotor values reduced mod 26 (sum is at most 75).
  function automatic logic [4:0] sum_mod26(input logic [4:0] a, input logic [4:0] b,
                                           input logic [4:0] c);
    logic [6:0] s;
    s = {2'b00, a} + {2'b00, b} + {2'b00, c};
    if (s >= 7'd52)      s = s - 7'd52;
    else if (s >= 7'd26) s = s - 7'd26;
    else                 s = s;
    return s[4:0];
  endfunction

  // (idx - off) mod 26 for idx, off in 0-25.
  function automatic logic [4:0] shift_back(input logic [4:0] idx, input logic [4:0] off);
    logic [5:0] d;
    d = {1'b0, idx} + 6'd26 - {1'b0, off};
    if (d >= 6'd26) d = d - 6'd26;
    else            d = d;
    return d[4:0];
  endfunction

  // Single rotor advance with wrap 25 -> 0.
  function automatic logic [4:0] step26(input logic [4:0] v);
    logic [4:0] r;
    if (v == 5'd25) r = 5'd0;
    else            r = v + 5'd1;
    return r;
  endfunction

  logic [4:0]         r1_r, r2_r, r3_r;
  logic [COUNT_W-1:0] count_r;
  logic               plain_valid_r;
  logic [7:0]         plain_out_r;

  logic               is_upper_s, is_lower_s, is_letter_s;
  logic [4:0]         offset_s, letter_idx_s;
  logic [7:0]         plain_next_s;
  logic               transfer_s;

  assign cipher_bus.cipher_ready = resetn && (!plain_valid_r || cipher_bus.plain_ready)
                                   && !load_init_state;
  assign transfer_s              = cipher_bus.cipher_valid && cipher_bus.cipher_ready;
  assign cipher_bus.plain_valid  = plain_valid_r;
  assign cipher_bus.plain_out    = plain_out_r;
  assign letter_count            = count_r;

  // Classify the incoming byte and compute its deciphered value.
  always_comb begin
    is_upper_s   = (cipher_bus.cipher_in >= 8'h41) && (cipher_bus.cipher_in <= 8'h5A);
    is_lower_s   = (cipher_bus.cipher_in >= 8'h61) && (cipher_bus.cipher_in <= 8'h7A);
    is_letter_s  = is_upper_s || is_lower_s;
    offset_s     = sum_mod26(r1_r, r2_r, r3_r);
    // 'A'..'Z' and 'a'..'z' both carry 1..26 in their low five bits.
    letter_idx_s = cipher_bus.cipher_in[4:0] - 5'd1;
    plain_next_s = cipher_bus.cipher_in;
    if (is_upper_s) begin
      plain_next_s = 8'h41 + {3'b000, shift_back(letter_idx_s, offset_s)};
    end else if (is_lower_s) begin
      plain_next_s = 8'h61 + {3'b000, shift_back(letter_idx_s, offset_s)};
    end else begin
      plain_next_s = cipher_bus.cipher_in;
    end
  end

  // Rotor positions and letter counter: load wins, otherwise step on letters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r1_r    <= 5'd0;
      r2_r    <= 5'd0;
      r3_r    <= 5'd0;
      count_r <= '0;
    end else if (load_init_state) begin
      r1_r    <= reduce_init(rotor_init_state);
      r2_r    <= reduce_init(rotor2_init_state);
      r3_r    <= reduce_init(rotor3_init_state);
      count_r <= '0;
    end else if (transfer_s && is_letter_s) begin
      r1_r <= step26(r1_r);
      if (r1_r == 5'd25) begin
        r2_r <= step26(r2_r);
        if (r2_r == 5'd25) begin
          r3_r <= step26(r3_r);
        end
      end
      count_r <= count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Output register: capture on transfer, release when consumed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      plain_valid_r <= 1'b0;
      plain_out_r   <= 8'h00;
    end else if (transfer_s) begin
      plain_valid_r <= 1'b1;
      plain_out_r   <= plain_next_s;
    end else if (cipher_bus.plain_ready) begin
      plain_valid_r <= 1'b0;
    end
  end

endmodule
